csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Machine-mode trap sequencer that owns the single write port of the CSR register file and shares it between the writeback-stage CSR instruction path and hardware trap entry/exit. On an exception, an enabled external interrupt, or `mret`, it stalls the pipeline and performs the required CSR updates one per cycle. It then issues a one-cycle PC redirect to the fetch stage. It sits between writeback, the CSR file, and the PC mux.

## Interface
- `MTVEC_VEC_EN`, default 1. 1 enables vectored mode (mtvec[1:0]==01); 0 treats every mode as direct.
- `clk` in 1. Clock; all state changes on the rising edge.
- `rst` in 1. Synchronous active-low reset: sampled at the rising edge, resets while low.
- `csrwriteW` in 1. Pipeline CSR write request.
- `csraddresW` in 12. Pipeline CSR write address.
- `RD1W` in 32. Pipeline CSR write data.
- `exc_valid` in 1. Synchronous exception from writeback.
- `exc_cause` in 32. Exception cause code (bit 31 is 0).
- `exc_pc` in 32. PC of the faulting instruction.
- `irq_ext` in 1. Level-sensitive machine external interrupt.
- `irq_pc` in 32. PC of the next unretired instruction (mepc value for interrupts).
- `mret_valid` in 1. `mret` retiring in writeback.
- `csr_we` out 1. CSR file write enable.
- `csr_waddr` out 12. CSR file write address.
- `csr_wdata` out 32. CSR file write data.
- `csr_raddr` out 12. CSR file read address.
- `csr_rdata` in 32. CSR file combinational read data.
- `stall` out 1. Freezes the pipeline.
- `redirect_valid` out 1. One-cycle PC redirect strobe.
- `redirect_pc` out 32. Redirect target.

## Operation
- CSR addresses used:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP bits 12:11.
  - mie 0x304: MEIE bit 11.
  - mtvec 0x305.
  - mepc 0x341.
  - mcause 0x342.
- Shadow bits `sh_mie` (mstatus.MIE) and `sh_meie` (mie.MEIE) snoop every write issued on the write port, including the block's own writes.
- An interrupt is pending when `irq_ext & sh_mie & sh_meie`. Its cause is 0x8000000B and its mepc is `irq_pc`.
- Acceptance in IDLE uses fixed priority: exception, then interrupt, then `mret`, then pipeline write.
  - An accepted trap or `mret` drops a same-cycle `csrwriteW`; that instruction is flushed.
- States:
  - **IDLE**: passes `csrwriteW`/`csraddresW`/`RD1W` straight to the write port.
    - On trap: latch pc and cause, go to W_MEPC.
    - On `mret`: go to R_MEPC.
  - **W_MEPC**: writes mepc = latched pc. Reads mtvec into `tvec_q`. Next state W_MCAUSE.
  - **W_MCAUSE**: writes mcause = latched cause. Next state W_MSTATUS.
  - **W_MSTATUS**: reads mstatus and writes it back modified: MPIE=MIE, MIE=0, MPP=2'b11, other bits unchanged. Target = `{tvec_q[31:2],2'b00}`; if vectored and cause[31]=1, add 4*cause[30:0]. Next state REDIRECT.
  - **R_MEPC**: reads mepc into the target register. Next state W_MRET.
  - **W_MRET**: reads mstatus and writes it back modified: MIE=MPIE, MPIE=1, MPP=2'b00. Next state REDIRECT.
  - **REDIRECT**: `redirect_valid`=1 with `redirect_pc`=target. No write. Next state IDLE.
- `csr_we`=0 in every non-IDLE state not listed as writing. In those states `csr_waddr`/`csr_wdata`/`csr_raddr` are don't-care but must be stable (hold 0).
- Pipeline inputs are ignored while not in IDLE; `stall` keeps the pipeline holding them.
- Address arithmetic is 32-bit with wrap; no overflow check.

## Timing
- Reset (`rst` low at an edge) forces:
  - state = IDLE;
  - latched pc, cause, tvec and target = 0;
  - shadow bits = 0;
  - all outputs = 0.
- Reset mid-sequence abandons the sequence immediately; partial CSR writes stay committed.
- `stall` = (state != IDLE) | (IDLE & accept of a trap or `mret`), combinational.
- Trap accepted at edge T:
  - CSR writes commit at edges T+1 (mepc), T+2 (mcause) and T+3 (mstatus);
  - `redirect_valid` is high during cycle T+3..T+4 (the REDIRECT state);
  - back in IDLE after edge T+4.
- `mret` accepted at edge T: mstatus write commits at T+2, REDIRECT in the following cycle, IDLE after T+3.
- The block accepts a new event in the first IDLE cycle after REDIRECT. A still-asserted `irq_ext` re-traps only if the shadow MIE is 1, which it is not after trap entry.
- Pipeline writes in IDLE have zero added latency: same-cycle pass-through, committed at the next edge.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with all requests high -> all outputs 0, state IDLE; no CSR changes.
- Pass-through: `csrwriteW`=1, addr 0x305, data 0x00000100 in IDLE -> `csr_we`=1 the same cycle, `stall`=0; mtvec=0x100 after the edge.
- Exception: mtvec=0x101, mstatus=0x8, `exc_cause`=2, `exc_pc`=0x40 ->
  - mepc=0x40, mcause=2;
  - mstatus=0x1880;
  - `redirect_pc`=0x100 for exactly one cycle;
  - `stall` high 4 cycles.
- Interrupt, vectored: mstatus.MIE=1, mie=0x800, mtvec=0x101, `irq_ext`=1, `irq_pc`=0x88 -> mcause=0x8000000B, mepc=0x88, `redirect_pc`=0x12C. With mie=0, no trap occurs.
- Mret: mepc=0x88, mstatus=0x1880, `mret_valid`=1 -> mstatus=0x88, `redirect_pc`=0x88 at cycle T+3.
- Collision and reset: same cycle `exc_valid`, `irq_ext` and `csrwriteW` -> exception taken, pipeline write dropped; assert `rst`=0 during W_MCAUSE -> IDLE next cycle, no redirect, mepc keeps the new value.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: owns the CSR write port, sequences trap
// entry / mret exit one CSR update per cycle, then redirects fetch.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   csrwriteW/csraddresW/RD1W   writeback CSR write request
//   exc_valid/exc_cause/exc_pc  synchronous exception
//   irq_ext/irq_pc      level external interrupt, its mepc value
//   mret_valid          mret retiring in writeback
//   csr_we/csr_waddr/csr_wdata  CSR file write port
//   csr_raddr/csr_rdata CSR file combinational read port
//   stall               pipeline freeze
//   redirect_valid/redirect_pc  one-cycle fetch redirect
module csr_trap_ctrl #(
    parameter bit MTVEC_VEC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrwriteW,
    input  logic [11:0] csraddresW,
    input  logic [31:0] RD1W,
    input  logic        exc_valid,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        irq_ext,
    input  logic [31:0] irq_pc,
    input  logic        mret_valid,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_R_MEPC,
        S_W_MRET,
        S_REDIRECT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic [31:0] tvec_q;
    logic [31:0] tgt_q;
    logic        sh_mie;
    logic        sh_meie;

    logic        irq_pend;
    logic        take_exc;
    logic        take_irq;
    logic        take_mret;
    logic        accept;

    logic        vec_hit;
    logic [31:0] vec_off;
    logic [31:0] trap_tgt;
    logic [31:0] ms_trap;
    logic [31:0] ms_ret;

    // Priority: exception > interrupt > mret; the three takes are
    // mutually exclusive by construction.
    assign irq_pend  = irq_ext & sh_mie & sh_meie;
    assign take_exc  = exc_valid;
    assign take_irq  = ~exc_valid & irq_pend;
    assign take_mret = ~exc_valid & ~irq_pend & mret_valid;
    assign accept    = (state_q == S_IDLE)
                     & (take_exc | take_irq | take_mret);

    // Vectored only for interrupts; 4*cause[30:0] wraps at 32 bits.
    assign vec_hit  = MTVEC_VEC_EN
                    & (tvec_q[1:0] == 2'b01)
                    & cause_q[31];
    assign vec_off  = vec_hit ? {cause_q[29:0], 2'b00} : 32'h0;
    assign trap_tgt = {tvec_q[31:2], 2'b00} + vec_off;

    // mstatus on trap entry: MPIE<=MIE, MIE<=0, MPP<=11.
    always_comb begin
        ms_trap        = csr_rdata;
        ms_trap[7]     = csr_rdata[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = 2'b11;
    end

    // mstatus on mret: MIE<=MPIE, MPIE<=1, MPP<=00.
    always_comb begin
        ms_ret        = csr_rdata;
        ms_ret[3]     = csr_rdata[7];
        ms_ret[7]     = 1'b1;
        ms_ret[12:11] = 2'b00;
    end

    // Outputs are forced low while reset is asserted so that a reset
    // cycle never commits a CSR write or redirects fetch.
    always_comb begin
        csr_we         = 1'b0;
        csr_waddr      = 12'h0;
        csr_wdata      = 32'h0;
        csr_raddr      = 12'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if (rst) begin
            unique case (state_q)
                S_IDLE: begin
                    stall     = accept;
                    csr_we    = csrwriteW & ~accept;
                    csr_waddr = csraddresW;
                    csr_wdata = RD1W;
                end
                S_W_MEPC: begin
                    stall     = 1'b1;
                    csr_we    = 1'b1;
                    csr_waddr = A_MEPC;
                    csr_wdata = pc_q;
                    csr_raddr = A_MTVEC;
                end
                S_W_MCAUSE: begin
                    stall     = 1'b1;
                    csr_we    = 1'b1;
                    csr_waddr = A_MCAUSE;
                    csr_wdata = cause_q;
                end
                S_W_MSTATUS: begin
                    stall     = 1'b1;
                    csr_we    = 1'b1;
                    csr_waddr = A_MSTATUS;
                    csr_wdata = ms_trap;
                    csr_raddr = A_MSTATUS;
                end
                S_R_MEPC: begin
                    stall     = 1'b1;
                    csr_raddr = A_MEPC;
                end
                S_W_MRET: begin
                    stall     = 1'b1;
                    csr_we    = 1'b1;
                    csr_waddr = A_MSTATUS;
                    csr_wdata = ms_ret;
                    csr_raddr = A_MSTATUS;
                end
                S_REDIRECT: begin
                    stall          = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = tgt_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
            tvec_q  <= 32'h0;
            tgt_q   <= 32'h0;
            sh_mie  <= 1'b0;
            sh_meie <= 1'b0;
        end else begin
            // Shadows follow every write on the port, ours included.
            if (csr_we && csr_waddr == A_MSTATUS) begin
                sh_mie <= csr_wdata[3];
            end
            if (csr_we && csr_waddr == A_MIE) begin
                sh_meie <= csr_wdata[11];
            end
            unique case (state_q)
                S_IDLE: begin
                    unique case (1'b1)
                        take_exc: begin
                            pc_q    <= exc_pc;
                            cause_q <= exc_cause;
                            state_q <= S_W_MEPC;
                        end
                        take_irq: begin
                            pc_q    <= irq_pc;
                            cause_q <= IRQ_CAUSE;
                            state_q <= S_W_MEPC;
                        end
                        take_mret: begin
                            state_q <= S_R_MEPC;
                        end
                        default: ;
                    endcase
                end
                S_W_MEPC: begin
                    tvec_q  <= csr_rdata;
                    state_q <= S_W_MCAUSE;
                end
                S_W_MCAUSE: begin
                    state_q <= S_W_MSTATUS;
                end
                S_W_MSTATUS: begin
                    tgt_q   <= trap_tgt;
                    state_q <= S_REDIRECT;
                end
                S_R_MEPC: begin
                    tgt_q   <= csr_rdata;
                    state_q <= S_W_MRET;
                end
                S_W_MRET: begin
                    state_q <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: CSR file model, per-cycle reference model
// of the trap sequencer, directed scenarios and random traffic.
module tb_csr_trap_ctrl;

    localparam bit VEC = 1'b1;

    bit clk;
    always #5 clk = ~clk;

    logic        rst;
    logic        csrwriteW;
    logic [11:0] csraddresW;
    logic [31:0] RD1W;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic        irq_ext;
    logic [31:0] irq_pc;
    logic        mret_valid;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    csr_trap_ctrl #(.MTVEC_VEC_EN(VEC)) dut (
        .clk(clk),
        .rst(rst),
        .csrwriteW(csrwriteW),
        .csraddresW(csraddresW),
        .RD1W(RD1W),
        .exc_valid(exc_valid),
        .exc_cause(exc_cause),
        .exc_pc(exc_pc),
        .irq_ext(irq_ext),
        .irq_pc(irq_pc),
        .mret_valid(mret_valid),
        .csr_we(csr_we),
        .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr),
        .csr_rdata(csr_rdata),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    // CSR file driven by the DUT write port.
    logic [31:0] mem [0:4095];
    assign csr_rdata = mem[csr_raddr];
    always @(posedge clk) begin
        if (csr_we) mem[csr_waddr] <= csr_wdata;
    end

    // Reference model state.
    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [31:0] d;
        logic        chk;
        logic        st;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] ref_csr [0:4095];
    logic        m_mie;
    logic        m_meie;
    logic        pend;
    logic        bad;

    int n_pass;
    int n_total;
    int stall_cnt;
    int rv_cnt;
    logic [31:0] last_rpc;

    function automatic exp_t mk(logic we, logic [11:0] a, logic [31:0] d,
                                logic chk, logic st, logic rv,
                                logic [31:0] rpc);
        exp_t r;
        r.we = we; r.a = a; r.d = d; r.chk = chk;
        r.st = st; r.rv = rv; r.rpc = rpc;
        return r;
    endfunction

    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause);
        logic [31:0] ms;
        logic [31:0] tv;
        logic [31:0] tgt;
        logic [31:0] nms;
        ms  = ref_csr[12'h300];
        tv  = ref_csr[12'h305];
        tgt = tv & ~32'h3;
        if (VEC && (tv & 32'h3) == 32'h1 && cause[31])
            tgt = tgt + (cause & 32'h7FFF_FFFF) * 4;
        nms = (ms & ~32'h1888) | (((ms >> 3) & 32'h1) << 7) | 32'h1800;
        q.push_back(mk(1'b1, 12'h341, pc, 1'b1, 1'b1, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 12'h342, cause, 1'b1, 1'b1, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 12'h300, nms, 1'b1, 1'b1, 1'b0, 32'h0));
        q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, tgt));
    endtask

    task automatic push_mret();
        logic [31:0] ms;
        logic [31:0] nms;
        ms  = ref_csr[12'h300];
        nms = (ms & ~32'h1888) | (((ms >> 7) & 32'h1) << 3) | 32'h80;
        q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 12'h300, nms, 1'b1, 1'b1, 1'b0, 32'h0));
        q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1,
                       ref_csr[12'h341]));
    endtask

    // Compare process: one check per cycle, mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            m_mie  = 1'b0;
            m_meie = 1'b0;
            e = mk(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        end else if (q.size() != 0) begin
            e = q.pop_front();
        end else begin
            pend = irq_ext && m_mie && m_meie;
            if (exc_valid || pend || mret_valid) begin
                e = mk(1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
                if (exc_valid) push_trap(exc_pc, exc_cause);
                else if (pend) push_trap(irq_pc, 32'h8000_000B);
                else push_mret();
            end else begin
                e = mk(csrwriteW, csraddresW, RD1W, csrwriteW,
                       1'b0, 1'b0, 32'h0);
            end
        end
        bad = (csr_we !== e.we) || (stall !== e.st)
           || (redirect_valid !== e.rv) || (redirect_pc !== e.rpc)
           || (e.chk && ((csr_waddr !== e.a) || (csr_wdata !== e.d)));
        n_total++;
        if (bad)
            $display("FAIL outcmp t=%0t got we=%b a=%h d=%h st=%b rv=%b pc=%h want we=%b a=%h d=%h st=%b rv=%b pc=%h",
                     $time, csr_we, csr_waddr, csr_wdata, stall,
                     redirect_valid, redirect_pc, e.we, e.a, e.d,
                     e.st, e.rv, e.rpc);
        else
            n_pass++;
        if (e.we) begin
            ref_csr[e.a] = e.d;
            if (e.a == 12'h300) m_mie = e.d[3];
            if (e.a == 12'h304) m_meie = e.d[11];
        end
        if (stall === 1'b1) stall_cnt++;
        if (redirect_valid === 1'b1) begin
            rv_cnt++;
            last_rpc = redirect_pc;
        end
    end

    task automatic lit(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s got %h want %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) go();
    endtask

    task automatic clr();
        exc_valid  = 1'b0;
        irq_ext    = 1'b0;
        mret_valid = 1'b0;
        csrwriteW  = 1'b0;
    endtask

    task automatic pw(input logic [11:0] a, input logic [31:0] d);
        csrwriteW  = 1'b1;
        csraddresW = a;
        RD1W       = d;
        go();
        csrwriteW  = 1'b0;
    endtask

    task automatic cnt_clr();
        stall_cnt = 0;
        rv_cnt    = 0;
        last_rpc  = 32'h0;
    endtask

    logic [11:0] atab [0:5];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'h0;
            ref_csr[i] = 32'h0;
        end
        atab[0] = 12'h300; atab[1] = 12'h304; atab[2] = 12'h305;
        atab[3] = 12'h341; atab[4] = 12'h342; atab[5] = 12'h340;
        n_pass = 0;
        n_total = 0;
        cnt_clr();
        m_mie = 1'b0;
        m_meie = 1'b0;

        // Reset with every request high.
        rst        = 1'b0;
        csrwriteW  = 1'b1;
        csraddresW = 12'h305;
        RD1W       = 32'hFFFF;
        exc_valid  = 1'b1;
        exc_cause  = 32'h5;
        exc_pc     = 32'h44;
        irq_ext    = 1'b1;
        irq_pc     = 32'h48;
        mret_valid = 1'b1;
        idle(3);
        lit("rst_mtvec", mem[12'h305], 32'h0);
        lit("rst_mepc", mem[12'h341], 32'h0);
        lit("rst_mstatus", mem[12'h300], 32'h0);
        rst = 1'b1;
        clr();

        // Same-cycle pass-through.
        csrwriteW  = 1'b1;
        csraddresW = 12'h305;
        RD1W       = 32'h100;
        #1;
        lit("pt_we", {31'h0, csr_we}, 32'h1);
        lit("pt_stall", {31'h0, stall}, 32'h0);
        go();
        csrwriteW = 1'b0;
        lit("pt_mtvec", mem[12'h305], 32'h100);

        // Exception.
        pw(12'h305, 32'h101);
        pw(12'h300, 32'h8);
        exc_valid = 1'b1;
        exc_cause = 32'h2;
        exc_pc    = 32'h40;
        go();
        clr();
        cnt_clr();
        idle(6);
        lit("exc_mepc", mem[12'h341], 32'h40);
        lit("exc_mcause", mem[12'h342], 32'h2);
        lit("exc_mstatus", mem[12'h300], 32'h1880);
        lit("exc_rv_cnt", rv_cnt, 32'd1);
        lit("exc_rpc", last_rpc, 32'h100);
        lit("exc_stall", stall_cnt, 32'd4);

        // Vectored interrupt; irq stays high, no re-trap.
        pw(12'h300, 32'h8);
        pw(12'h304, 32'h800);
        irq_ext = 1'b1;
        irq_pc  = 32'h88;
        go();
        cnt_clr();
        idle(6);
        irq_ext = 1'b0;
        lit("irq_mcause", mem[12'h342], 32'h8000_000B);
        lit("irq_mepc", mem[12'h341], 32'h88);
        lit("irq_rpc", last_rpc, 32'h12C);
        lit("irq_stall", stall_cnt, 32'd4);

        // Interrupt masked by mie.
        pw(12'h300, 32'h8);
        pw(12'h304, 32'h0);
        irq_ext = 1'b1;
        cnt_clr();
        idle(5);
        irq_ext = 1'b0;
        lit("irq_masked", stall_cnt, 32'd0);

        // mret.
        pw(12'h300, 32'h1880);
        mret_valid = 1'b1;
        go();
        mret_valid = 1'b0;
        cnt_clr();
        idle(5);
        lit("mret_mstatus", mem[12'h300], 32'h88);
        lit("mret_rpc", last_rpc, 32'h88);
        lit("mret_rv_cnt", rv_cnt, 32'd1);

        // Collision, then reset during mcause write.
        pw(12'h300, 32'h8);
        pw(12'h304, 32'h800);
        exc_valid  = 1'b1;
        exc_cause  = 32'h7;
        exc_pc     = 32'h200;
        irq_ext    = 1'b1;
        irq_pc     = 32'h300;
        csrwriteW  = 1'b1;
        csraddresW = 12'h340;
        RD1W       = 32'hDEAD;
        go();
        clr();
        go();
        rst = 1'b0;
        cnt_clr();
        go();
        rst = 1'b1;
        idle(5);
        lit("col_mepc", mem[12'h341], 32'h200);
        lit("col_mcause", mem[12'h342], 32'h8000_000B);
        lit("col_drop", mem[12'h340], 32'h0);
        lit("col_rv_cnt", rv_cnt, 32'd0);
        lit("col_stall", stall_cnt, 32'd0);

        // Random traffic.
        repeat (3000) begin
            rst        = ($urandom_range(0, 63) != 0);
            exc_valid  = ($urandom_range(0, 15) == 0);
            exc_cause  = $urandom() & 32'h7FFF_FFFF;
            exc_pc     = $urandom();
            irq_ext    = ($urandom_range(0, 3) == 0);
            irq_pc     = $urandom();
            mret_valid = ($urandom_range(0, 15) == 0);
            csrwriteW  = ($urandom_range(0, 1) == 1);
            csraddresW = atab[$urandom_range(0, 5)];
            RD1W       = $urandom();
            go();
        end
        clr();
        rst = 1'b1;
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
